// File: rtl/pll_dyn_cfg_ctrl.sv
// Reset/divider sequencer for an rPLL in dynamic-divider mode: boot, reconfigure, lock qualify, retry.
// Optional build macro PLL_LOCK_RECOVERY_EN: lock loss in RUN re-sequences instead of failing.
module pll_dyn_cfg_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [5:0]  INIT_IDSEL   = 6'd0,
  parameter logic [5:0]  INIT_FBDSEL  = 6'd0,
  parameter logic [5:0]  INIT_ODSEL   = 6'd0,
  parameter logic [3:0]  INIT_PSDA    = 4'd0,
  parameter logic [3:0]  INIT_DUTYDA  = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  input  logic [3:0] cfg_psda,
  input  logic [3:0] cfg_dutyda,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       pll_reset_p,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic [3:0] pll_psda,
  output logic [3:0] pll_dutyda,
  output logic       locked,
  output logic       busy,
  output logic       err
);

  localparam int unsigned HW = $clog2(RST_CYCLES + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_e;

  state_e        state_q, state_d;
  logic          lock_meta_q, lock_s_q;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [RW-1:0] retry_q, retry_d;

  logic [5:0] idsel_q, fbdsel_q, odsel_q;
  logic [3:0] psda_q, dutyda_q;

  logic pll_reset_q, pll_reset_d;
  logic locked_q, locked_d;
  logic busy_q, busy_d;
  logic ready_q, ready_d;
  logic err_q, err_d;

  logic accept;
  logic hold_done, timeout, stab_done;

  assign accept    = cfg_valid & ready_q;
  assign hold_done = (hold_cnt_q >= HOLD_LAST);
  assign timeout   = (to_cnt_q >= TO_LAST);
  assign stab_done = (stab_cnt_q >= STAB_LAST);

  // LOCK is asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= '0;
      to_cnt_q    <= '0;
      stab_cnt_q  <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  // Codes only load on accept, which always coincides with pll_reset going/staying high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idsel_q  <= INIT_IDSEL;
      fbdsel_q <= INIT_FBDSEL;
      odsel_q  <= INIT_ODSEL;
      psda_q   <= INIT_PSDA;
      dutyda_q <= INIT_DUTYDA;
    end else if (accept) begin
      idsel_q  <= cfg_idsel;
      fbdsel_q <= cfg_fbdsel;
      odsel_q  <= cfg_odsel;
      psda_q   <= cfg_psda;
      dutyda_q <= cfg_dutyda;
    end
  end

  // Next-state and retry bookkeeping
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    unique case (state_q)
      S_HOLD: begin
        if (hold_done) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (timeout) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_HOLD;
          end else begin
            state_d = S_FAIL;
          end
        end else if (lock_s_q) begin
          state_d = S_STABLE;
        end
      end
      S_STABLE: begin
        // A completed qualification wins over a coincident timeout
        if (lock_s_q && stab_done) begin
          state_d = S_RUN;
        end else if (timeout) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_HOLD;
          end else begin
            state_d = S_FAIL;
          end
        end else if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
`ifdef PLL_LOCK_RECOVERY_EN
          retry_d = '0;
          state_d = S_HOLD;
`else
          state_d = S_FAIL;
`endif
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
    if (accept) begin
      retry_d = '0;
      state_d = S_HOLD;
    end
  end

  // Saturating counters; each is cleared whenever its owning phase is left
  always_comb begin
    hold_cnt_d = '0;
    to_cnt_d   = '0;
    stab_cnt_d = '0;
    if (state_q == S_HOLD && state_d == S_HOLD) begin
      hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HW'(1);
    end
    if ((state_q == S_WAIT_LOCK || state_q == S_STABLE) &&
        (state_d == S_WAIT_LOCK || state_d == S_STABLE)) begin
      to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TW'(1);
    end
    if (state_d == S_STABLE) begin
      if (state_q == S_STABLE) begin
        stab_cnt_d = (stab_cnt_q == '1) ? stab_cnt_q : stab_cnt_q + SW'(1);
      end else begin
        stab_cnt_d = SW'(1);
      end
    end
  end

  // Outputs decoded from the next state and registered, so PLL RESET never glitches
  always_comb begin
    pll_reset_d = 1'b0;
    locked_d    = 1'b0;
    busy_d      = 1'b0;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    unique case (state_d)
      S_HOLD: begin
        pll_reset_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_WAIT_LOCK, S_STABLE: begin
        busy_d = 1'b1;
      end
      S_RUN: begin
        locked_d = 1'b1;
        ready_d  = 1'b1;
      end
      S_FAIL: begin
        pll_reset_d = 1'b1;
        ready_d     = 1'b1;
        err_d       = 1'b1;
      end
      default: begin
        pll_reset_d = 1'b1;
        busy_d      = 1'b1;
      end
    endcase
  end

  assign pll_reset   = pll_reset_q;
  assign pll_reset_p = pll_reset_q;
  assign pll_idsel   = idsel_q;
  assign pll_fbdsel  = fbdsel_q;
  assign pll_odsel   = odsel_q;
  assign pll_psda    = psda_q;
  assign pll_dutyda  = dutyda_q;
  assign locked      = locked_q;
  assign busy        = busy_q;
  assign cfg_ready   = ready_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Directed bench for pll_dyn_cfg_ctrl: boot, reconfig, lock glitch, lock loss, timeout/retry, async reset.
module tb_pll_dyn_cfg_ctrl;

  localparam logic [5:0] I_ID = 6'h05;
  localparam logic [5:0] I_FB = 6'h0A;
  localparam logic [5:0] I_OD = 6'h14;
  localparam logic [3:0] I_PS = 4'h3;
  localparam logic [3:0] I_DU = 4'h8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
  logic [3:0] cfg_psda, cfg_dutyda;
  logic       pll_lock;
  logic       pll_reset, pll_reset_p;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [3:0] pll_psda, pll_dutyda;
  logic       locked, busy, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pll_dyn_cfg_ctrl #(
    .RST_CYCLES  (4),
    .LOCK_TIMEOUT(100),
    .LOCK_STABLE (8),
    .MAX_RETRY   (2),
    .INIT_IDSEL  (I_ID),
    .INIT_FBDSEL (I_FB),
    .INIT_ODSEL  (I_OD),
    .INIT_PSDA   (I_PS),
    .INIT_DUTYDA (I_DU)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_idsel  (cfg_idsel),
    .cfg_fbdsel (cfg_fbdsel),
    .cfg_odsel  (cfg_odsel),
    .cfg_psda   (cfg_psda),
    .cfg_dutyda (cfg_dutyda),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_reset_p(pll_reset_p),
    .pll_idsel  (pll_idsel),
    .pll_fbdsel (pll_fbdsel),
    .pll_odsel  (pll_odsel),
    .pll_psda   (pll_psda),
    .pll_dutyda (pll_dutyda),
    .locked     (locked),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    int         n;
    logic       lock;
    logic       valid;
    logic [5:0] id, fb, od;
    logic [3:0] ps, du;
    logic       e_rst, e_lck, e_busy, e_rdy, e_err;
    logic [5:0] e_id, e_fb, e_od;
    logic [3:0] e_ps, e_du;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_codes(input string tag, input logic [5:0] id, input logic [5:0] fb,
                           input logic [5:0] od, input logic [3:0] ps, input logic [3:0] du);
    chk({tag, ".idsel"},  32'(pll_idsel),  32'(id));
    chk({tag, ".fbdsel"}, 32'(pll_fbdsel), 32'(fb));
    chk({tag, ".odsel"},  32'(pll_odsel),  32'(od));
    chk({tag, ".psda"},   32'(pll_psda),   32'(ps));
    chk({tag, ".dutyda"}, 32'(pll_dutyda), 32'(du));
  endtask

  task automatic chk_flags(input string tag, input logic r, input logic l, input logic b,
                           input logic y, input logic e);
    chk({tag, ".pll_reset"},   32'(pll_reset),   32'(r));
    chk({tag, ".pll_reset_p"}, 32'(pll_reset_p), 32'(r));
    chk({tag, ".locked"},      32'(locked),      32'(l));
    chk({tag, ".busy"},        32'(busy),        32'(b));
    chk({tag, ".cfg_ready"},   32'(cfg_ready),   32'(y));
    chk({tag, ".err"},         32'(err),         32'(e));
  endtask

  task automatic send_cfg(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od,
                          input logic [3:0] ps, input logic [3:0] du);
    cfg_valid  = 1'b1;
    cfg_idsel  = id;
    cfg_fbdsel = fb;
    cfg_odsel  = od;
    cfg_psda   = ps;
    cfg_dutyda = du;
    tick(1);
    cfg_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_r;
    bit   got;

    // Boot (T1) then reconfig (T2), one record per checkpoint after n edges
    tbl[0] = '{3,  1'b0, 1'b0, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, I_ID,  I_FB,  I_OD,  I_PS, I_DU};
    tbl[1] = '{1,  1'b0, 1'b0, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, I_ID,  I_FB,  I_OD,  I_PS, I_DU};
    tbl[2] = '{20, 1'b0, 1'b0, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, I_ID,  I_FB,  I_OD,  I_PS, I_DU};
    tbl[3] = '{9,  1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, I_ID,  I_FB,  I_OD,  I_PS, I_DU};
    tbl[4] = '{1,  1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, I_ID,  I_FB,  I_OD,  I_PS, I_DU};
    tbl[5] = '{1,  1'b1, 1'b1, 6'h3F, 6'h31, 6'h38, 4'h5, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h31, 6'h38, 4'h5, 4'h6};
    tbl[6] = '{3,  1'b1, 1'b0, 6'h3F, 6'h31, 6'h38, 4'h5, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h31, 6'h38, 4'h5, 4'h6};
    tbl[7] = '{1,  1'b1, 1'b0, 6'h3F, 6'h31, 6'h38, 4'h5, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h31, 6'h38, 4'h5, 4'h6};
    tbl[8] = '{7,  1'b1, 1'b1, 6'h01, 6'h02, 6'h03, 4'h1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h31, 6'h38, 4'h5, 4'h6};
    tbl[9] = '{1,  1'b1, 1'b0, 6'h3F, 6'h31, 6'h38, 4'h5, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h3F, 6'h31, 6'h38, 4'h5, 4'h6};

    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_idsel  = '0;
    cfg_fbdsel = '0;
    cfg_odsel  = '0;
    cfg_psda   = '0;
    cfg_dutyda = '0;
    pll_lock   = 1'b0;
    tick(3);
    chk_flags("reset", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_codes("reset", I_ID, I_FB, I_OD, I_PS, I_DU);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      pll_lock   = tbl[i].lock;
      cfg_valid  = tbl[i].valid;
      cfg_idsel  = tbl[i].id;
      cfg_fbdsel = tbl[i].fb;
      cfg_odsel  = tbl[i].od;
      cfg_psda   = tbl[i].ps;
      cfg_dutyda = tbl[i].du;
      tick(tbl[i].n);
      chk_flags($sformatf("v%0d", i), tbl[i].e_rst, tbl[i].e_lck, tbl[i].e_busy,
                tbl[i].e_rdy, tbl[i].e_err);
      chk_codes($sformatf("v%0d", i), tbl[i].e_id, tbl[i].e_fb, tbl[i].e_od,
                tbl[i].e_ps, tbl[i].e_du);
    end
    cfg_valid = 1'b0;

    // T3: 5 high samples, 1 low sample, then steady high; qualification restarts
    pll_lock = 1'b0;
    send_cfg(6'h11, 6'h22, 6'h33, 4'h4, 4'h9);
    chk("t3.accept_reset", 32'(pll_reset), 32'd1);
    chk("t3.accept_idsel", 32'(pll_idsel), 32'h11);
    tick(4);
    chk("t3.release", 32'(pll_reset), 32'd0);
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(2);
    chk("t3.glitch_busy", 32'(busy), 32'd1);
    chk("t3.glitch_locked", 32'(locked), 32'd0);
    tick(2);
    chk("t3.no_early_lock", 32'(locked), 32'd0);
    tick(5);
    chk("t3.seven_high", 32'(locked), 32'd0);
    tick(1);
    chk("t3.eight_high", 32'(locked), 32'd1);
    chk("t3.ready", 32'(cfg_ready), 32'd1);

    // T5: lock loss in RUN, seen by the FSM 3 edges after the pin drops
    pll_lock = 1'b0;
    tick(2);
    chk("t5.still_locked", 32'(locked), 32'd1);
    tick(1);
`ifdef PLL_LOCK_RECOVERY_EN
    chk_flags("t5.recover", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pll_lock = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick(1);
      got = locked;
    end
    chk("t5.relock", 32'(got), 32'd1);
    chk("t5.err", 32'(err), 32'd0);
    chk("t5.idsel_kept", 32'(pll_idsel), 32'h11);
`else
    chk_flags("t5.fail", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5.idsel_kept", 32'(pll_idsel), 32'h11);
`endif

    // T4: lock never arrives -> pulses at 0, 104, 208 then FAIL from 312
    pll_lock = 1'b0;
    send_cfg(6'h07, 6'h08, 6'h09, 4'h1, 4'h2);
    chk("t4.err_cleared", 32'(err), 32'd0);
    chk_codes("t4", 6'h07, 6'h08, 6'h09, 4'h1, 4'h2);
    for (int k = 0; k < 320; k++) begin
      if (k > 0) tick(1);
      exp_r = (k < 4) || (k >= 104 && k < 108) || (k >= 208 && k < 212) || (k >= 312);
      if (pll_reset !== exp_r) begin
        chk($sformatf("t4.pll_reset@%0d", k), 32'(pll_reset), 32'(exp_r));
      end else begin
        checks++;
      end
    end
    chk_flags("t4.fail", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // T6: async reset during WAIT_LOCK, checked before any clock edge
    send_cfg(6'h2A, 6'h15, 6'h3C, 4'hF, 4'h0);
    chk("t6.idsel", 32'(pll_idsel), 32'h2A);
    tick(6);
    chk("t6.wait_lock", 32'(pll_reset), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    chk_flags("t6.async", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_codes("t6.async", I_ID, I_FB, I_OD, I_PS, I_DU);
    tick(2);
    rst = 1'b0;
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
